// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory responder: word-addressed array with byte-strobed writes and a
// programmable read latency. Read and write channels run fully independently.
module axi_lite_mem_slave #(
  parameter int          ADDR_WIDTH   = 64,
  parameter int          DATA_WIDTH   = 64,
  parameter int          MEM_DEPTH    = 1024,
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  parameter int          READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [1:0]              w_state_dbg,
  output logic [1:0]              r_state_dbg
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(STRB_W);
  localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  // Handshakes: a transfer happens on the edge where valid && ready are both high;
  // valid never drops without ready and payloads stay frozen while valid is high.

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >= BASE_A) && (((addr - BASE_A) >> OFF_BITS) < DEPTH_A);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'((addr - BASE_A) >> OFF_BITS);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  live;
  w_state_t              w_state, w_next;
  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] aw_q, ar_q, c_addr, s_addr;
  logic [DATA_WIDTH-1:0] w_q, c_data;
  logic [STRB_W-1:0]     ws_q, c_strb;
  logic                  commit, latch_aw, latch_w, sample, ar_take;
  logic [CNT_W-1:0]      cnt;

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) live <= 1'b0;
    else       live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next   = w_state;
    awready  = 1'b0;
    wready   = 1'b0;
    commit   = 1'b0;
    latch_aw = 1'b0;
    latch_w  = 1'b0;
    c_addr   = aw_q;
    c_data   = w_q;
    c_strb   = ws_q;
    case (w_state)
      W_IDLE: begin
        awready = live;
        wready  = live;
        if (live && awvalid && wvalid) begin
          commit = 1'b1;
          c_addr = awaddr;
          c_data = wdata;
          c_strb = wstrb;
          w_next = W_RESP;
        end else if (live && awvalid) begin
          latch_aw = 1'b1;
          w_next   = W_GOT_AW;
        end else if (live && wvalid) begin
          latch_w = 1'b1;
          w_next  = W_GOT_W;
        end
      end
      W_GOT_AW: begin
        wready = live;
        if (live && wvalid) begin
          commit = 1'b1;
          c_data = wdata;
          c_strb = wstrb;
          w_next = W_RESP;
        end
      end
      W_GOT_W: begin
        awready = live;
        if (live && awvalid) begin
          commit = 1'b1;
          c_addr = awaddr;
          w_next = W_RESP;
        end
      end
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  assign ar_take = (r_state == R_IDLE) && arvalid && live;

  // The counter holds the remaining wait cycles; the array is sampled on the
  // edge where it would step to zero, so rvalid rises READ_LATENCY cycles after AR.
  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    sample  = 1'b0;
    s_addr  = ar_q;
    case (r_state)
      R_IDLE: begin
        arready = live;
        if (ar_take) begin
          if (READ_LATENCY == 1) begin
            sample = 1'b1;
            s_addr = araddr;
            r_next = R_RESP;
          end else begin
            r_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          sample = 1'b1;
          r_next = R_RESP;
        end
      end
      R_RESP:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_q  <= '0;
      w_q   <= '0;
      ws_q  <= '0;
      ar_q  <= '0;
      cnt   <= '0;
      bresp <= 2'b00;
      rresp <= 2'b00;
      rdata <= '0;
    end else begin
      if (latch_aw) aw_q <= awaddr;
      if (latch_w) begin
        w_q  <= wdata;
        ws_q <= wstrb;
      end
      if (ar_take)               ar_q <= araddr;
      if (ar_take)               cnt  <= CNT_W'(READ_LATENCY - 1);
      else if (r_state == R_WAIT) cnt <= cnt - 1'b1;
      if (commit)
        bresp <= in_range(c_addr) ? RESP_OKAY : RESP_SLVERR;
      else if (bvalid && bready)
        bresp <= 2'b00;
      if (sample) begin
        rdata <= in_range(s_addr) ? mem[word_idx(s_addr)] : '0;
        rresp <= in_range(s_addr) ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid && rready) begin
        rdata <= '0;
        rresp <= 2'b00;
      end
    end
  end

  // Nonblocking array update: a read sampled on the commit edge sees the old word.
  always_ff @(posedge clk) begin
    if (commit && in_range(c_addr)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (c_strb[b]) mem[word_idx(c_addr)][8*b +: 8] <= c_data[8*b +: 8];
      end
    end
  end

  assign bvalid      = (w_state == W_RESP);
  assign rvalid      = (r_state == R_RESP);
  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;

endmodule
